// File: rtl/traffic_pkg.sv
// Shared types for the intersection controller: phase and road-direction enums
// plus small elaboration-time helpers.
package traffic_pkg;

  typedef enum logic [2:0] {
    ALLRED = 3'd0,
    REDYLW = 3'd1,
    GREEN  = 3'd2,
    YELLOW = 3'd3,
    WALK   = 3'd4
  } tl_state_t;

  typedef enum logic {
    DIR_NS = 1'b0,
    DIR_EW = 1'b1
  } tl_dir_t;

  function automatic tl_dir_t other_dir(input tl_dir_t d);
    return (d == DIR_NS) ? DIR_EW : DIR_NS;
  endfunction

  // True when a phase time is legal and t-1 fits in a w-bit counter.
  function automatic logic cnt_fits(input int t, input int w);
    return (t >= 32'sd1) && ((t - 32'sd1) < (32'sd1 <<< w));
  endfunction

endpackage

// File: rtl/intersection_ctrl_chk.sv
// Safety properties on the lamp outputs of intersection_ctrl.
module intersection_ctrl_chk (
  input logic clk,
  input logic rst,
  input logic ns_green,
  input logic ns_yellow,
  input logic ew_green,
  input logic ew_yellow,
  input logic walk,
  input logic ped_ack
);

  a_no_dual_green: assert property (@(posedge clk) disable iff (!rst)
    !(ns_green && ew_green));

  a_no_drive_during_walk: assert property (@(posedge clk) disable iff (!rst)
    !(walk && (ns_green || ns_yellow || ew_green || ew_yellow)));

  a_ack_inside_walk: assert property (@(posedge clk) disable iff (!rst)
    ped_ack |-> walk);

  a_ack_single_cycle: assert property (@(posedge clk) disable iff (!rst)
    ped_ack |=> !ped_ack);

  a_ack_on_walk_start: assert property (@(posedge clk) disable iff (!rst)
    $rose(walk) |-> ped_ack);

endmodule

// File: rtl/phase_timer.sv
// Loadable down-counter that saturates at zero; done flags the final cycle of a phase.
module phase_timer #(
  parameter int               CNT_W   = 8,
  parameter logic [CNT_W-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic [CNT_W-1:0] cnt,
  output logic             done
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // next count: load wins, otherwise count down and hold at zero
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CNT_W'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // counter register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= RST_VAL;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt  = cnt_q;
  assign done = (cnt_q == '0);

endmodule

// File: rtl/intersection_ctrl.sv
// Two-road intersection sequencer with all-red clearance, green extension and
// latched pedestrian walk service. Lamps decode directly from registered state.
module intersection_ctrl
  import traffic_pkg::*;
#(
  parameter int REDYLW_T = 2,
  parameter int GREEN_T  = 6,
  parameter int YELLOW_T = 2,
  parameter int ALLRED_T = 1,
  parameter int WALK_T   = 4,
  parameter int CNT_W    = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic car_ns,
  input  logic car_ew,
  input  logic ped_req,
  output logic ns_red,
  output logic ns_yellow,
  output logic ns_green,
  output logic ew_red,
  output logic ew_yellow,
  output logic ew_green,
  output logic walk,
  output logic ped_ack
);

  if (!cnt_fits(REDYLW_T, CNT_W) || !cnt_fits(GREEN_T, CNT_W) ||
      !cnt_fits(YELLOW_T, CNT_W) || !cnt_fits(ALLRED_T, CNT_W) ||
      !cnt_fits(WALK_T, CNT_W)) begin : g_param_err
    $error("intersection_ctrl: a phase time is < 1 or does not fit in CNT_W bits");
  end

  tl_state_t        state_q, state_d;
  tl_dir_t          dir_q, dir_d;
  tl_dir_t          next_dir_q, next_dir_d;
  logic             ped_pending_q, ped_pending_d;
  logic             walk_entry;
  logic             opp_demand;
  logic             tmr_load;
  logic [CNT_W-1:0] tmr_load_val;
  logic [CNT_W-1:0] tmr_cnt;
  logic             tmr_done;
  logic             lamp_red, lamp_yel, lamp_grn;

  phase_timer #(
    .CNT_W   (CNT_W),
    .RST_VAL (CNT_W'(ALLRED_T - 1))
  ) u_timer (
    .clk      (clk),
    .rst_n    (rst),
    .load     (tmr_load),
    .load_val (tmr_load_val),
    .cnt      (tmr_cnt),
    .done     (tmr_done)
  );

  assign opp_demand = (dir_q == DIR_NS) ? car_ew : car_ns;

  // phase sequencing, direction bookkeeping and timer reload
  always_comb begin
    state_d      = state_q;
    dir_d        = dir_q;
    next_dir_d   = next_dir_q;
    walk_entry   = 1'b0;
    tmr_load_val = '0;
    case (state_q)
      ALLRED: begin
        if (tmr_done && ped_pending_q) begin
          state_d    = WALK;
          walk_entry = 1'b1;
        end else if (tmr_done) begin
          state_d = REDYLW;
          dir_d   = next_dir_q;
        end else begin
          state_d = ALLRED;
        end
      end
      WALK: begin
        if (tmr_done) begin
          state_d = REDYLW;
          dir_d   = next_dir_q;
        end else begin
          state_d = WALK;
        end
      end
      REDYLW: begin
        if (tmr_done) state_d = GREEN;
        else          state_d = REDYLW;
      end
      // Green holds past its minimum until someone else is waiting.
      GREEN: begin
        if (tmr_done && (opp_demand || ped_pending_q)) state_d = YELLOW;
        else                                           state_d = GREEN;
      end
      YELLOW: begin
        if (tmr_done) begin
          state_d    = ALLRED;
          next_dir_d = other_dir(dir_q);
        end else begin
          state_d = YELLOW;
        end
      end
      default: state_d = ALLRED;
    endcase

    tmr_load = (state_d != state_q);
    case (state_d)
      ALLRED:  tmr_load_val = CNT_W'(ALLRED_T - 1);
      REDYLW:  tmr_load_val = CNT_W'(REDYLW_T - 1);
      GREEN:   tmr_load_val = CNT_W'(GREEN_T - 1);
      YELLOW:  tmr_load_val = CNT_W'(YELLOW_T - 1);
      WALK:    tmr_load_val = CNT_W'(WALK_T - 1);
      default: tmr_load_val = '0;
    endcase
  end

  // A request in the WALK-entry cycle re-arms the latch rather than being lost.
  assign ped_pending_d = (ped_pending_q && !walk_entry) || ped_req;

  // controller state registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= ALLRED;
      dir_q         <= DIR_NS;
      next_dir_q    <= DIR_NS;
      ped_pending_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      dir_q         <= dir_d;
      next_dir_q    <= next_dir_d;
      ped_pending_q <= ped_pending_d;
    end
  end

  // Moore lamp decode; the inactive road always shows red
  always_comb begin
    lamp_red = 1'b1;
    lamp_yel = 1'b0;
    lamp_grn = 1'b0;
    walk     = 1'b0;
    ped_ack  = 1'b0;
    case (state_q)
      ALLRED: lamp_red = 1'b1;
      REDYLW: lamp_yel = 1'b1;
      GREEN: begin
        lamp_red = 1'b0;
        lamp_grn = 1'b1;
      end
      YELLOW: begin
        lamp_red = 1'b0;
        lamp_yel = 1'b1;
      end
      WALK: begin
        walk    = 1'b1;
        ped_ack = (tmr_cnt == CNT_W'(WALK_T - 1));
      end
      default: lamp_red = 1'b1;
    endcase

    if (dir_q == DIR_NS) begin
      ns_red    = lamp_red;
      ns_yellow = lamp_yel;
      ns_green  = lamp_grn;
      ew_red    = 1'b1;
      ew_yellow = 1'b0;
      ew_green  = 1'b0;
    end else begin
      ns_red    = 1'b1;
      ns_yellow = 1'b0;
      ns_green  = 1'b0;
      ew_red    = lamp_red;
      ew_yellow = lamp_yel;
      ew_green  = lamp_grn;
    end
  end

endmodule
